// File: rtl/second_layer_tnndirect_pkg.sv
// Shared types and helpers for the direct ternary NN output layer.
// Contents: FSM state enum, score/counter width helpers, ternary MAC term.
package second_layer_tnndirect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Signed score width able to hold +/-h without overflow.
  function automatic int unsigned score_bits(input int unsigned h);
    return $clog2(h + 1) + 1;
  endfunction

  // Counter width for n items, never below one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Ternary weight times binary activation: 0 when masked, else +1 on sign match, -1 otherwise.
  function automatic logic signed [1:0] tern_mac(input logic sign, input logic nz, input logic x);
    if (!nz) return 2'sb00;
    return (sign ~^ x) ? 2'sb01 : 2'sb11;
  endfunction

endpackage

// File: rtl/second_layer_tnndirect_if.sv
// Upstream/result bundle of the output layer.
// start/hidden: level launch and activations from the first layer.
// class_idx/done: argmax result and sticky valid flag.
interface second_layer_tnndirect_if #(
  parameter int unsigned HIDDEN_CNT = 4,
  parameter int unsigned CLASS_CNT  = 3
);
  localparam int unsigned IDX_W = $clog2(CLASS_CNT);

  logic                  start;
  logic [HIDDEN_CNT-1:0] hidden;
  logic [IDX_W-1:0]      class_idx;
  logic                  done;

  modport master (output start, output hidden, input class_idx, input done);
  modport slave  (input start, input hidden, output class_idx, output done);
endinterface

// File: rtl/second_layer_tnndirect_acc.sv
// Per-class signed score accumulator.
// clk/rst: clock and async active-high reset; clr: zero the score;
// en: add tern_mac(sign, nz, x); score: running signed total.
module second_layer_tnndirect_acc
  import second_layer_tnndirect_pkg::*;
#(
  parameter int unsigned SB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 sign,
  input  logic                 nz,
  input  logic                 x,
  output logic signed [SB-1:0] score
);

  // Clear has priority; the size cast sign-extends the 2-bit term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      score <= '0;
    else if (clr) score <= '0;
    else if (en)  score <= score + SB'(tern_mac(sign, nz, x));
  end

endmodule

// File: rtl/second_layer_tnndirect.sv
// Output layer of the direct ternary NN: serial accumulate over hidden bits,
// then serial argmax over class scores.
// clk/rst: clock and async active-high reset.
// bus (slave): start/hidden in, class_idx/done out (done is sticky until rst).
module second_layer_tnndirect
  import second_layer_tnndirect_pkg::*;
#(
  parameter int unsigned                      HIDDEN_CNT = 4,
  parameter int unsigned                      CLASS_CNT  = 3,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] WEIGHTS    = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] MASK       = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  second_layer_tnndirect_if.slave bus
);

  localparam int unsigned SB = score_bits(HIDDEN_CNT);
  localparam int unsigned HW = cnt_bits(HIDDEN_CNT);
  localparam int unsigned IW = $clog2(CLASS_CNT);
  localparam logic [HW-1:0] H_LAST = HW'(HIDDEN_CNT - 1);
  localparam logic [IW-1:0] C_LAST = IW'(CLASS_CNT - 1);

  state_t                 state, state_nx;
  logic                   acc_clr_c, acc_en_c;
  logic [HW-1:0]          h_cnt;
  logic [IW-1:0]          c_cnt;
  logic [HIDDEN_CNT-1:0]  hid_q;
  logic signed [SB-1:0]   best;
  logic [IW-1:0]          best_idx;
  logic [CLASS_CNT-1:0]   w_tab [HIDDEN_CNT];
  logic [CLASS_CNT-1:0]   m_tab [HIDDEN_CNT];
  logic [CLASS_CNT-1:0]   w_col, m_col;
  logic signed [SB-1:0]   score [CLASS_CNT];
  logic                   take_c;
  logic [IW-1:0]          win_idx_c;

  // Weight/mask rows indexed by hidden bit; each row holds one bit per class.
  for (genvar h = 0; h < HIDDEN_CNT; h++) begin : g_row
    assign w_tab[h] = WEIGHTS[h*CLASS_CNT +: CLASS_CNT];
    assign m_tab[h] = MASK[h*CLASS_CNT +: CLASS_CNT];
  end

  assign w_col = w_tab[h_cnt];
  assign m_col = m_tab[h_cnt];

  for (genvar c = 0; c < CLASS_CNT; c++) begin : g_acc
    second_layer_tnndirect_acc #(.SB(SB)) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (acc_clr_c),
      .en    (acc_en_c),
      .sign  (w_col[c]),
      .nz    (m_col[c]),
      .x     (hid_q[h_cnt]),
      .score (score[c])
    );
  end

  // First argmax step loads unconditionally; later steps need a strictly greater score.
  assign take_c    = (c_cnt == '0) || (score[c_cnt] > best);
  assign win_idx_c = take_c ? c_cnt : best_idx;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and accumulator controls.
  always_comb begin
    state_nx  = state;
    acc_clr_c = 1'b0;
    acc_en_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx  = ACCUM;
          acc_clr_c = 1'b1;
        end
      end
      ACCUM: begin
        acc_en_c = 1'b1;
        if (h_cnt == H_LAST) state_nx = ARGMAX;
      end
      ARGMAX: begin
        if (c_cnt == C_LAST) state_nx = DONE;
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters, hidden latch, argmax registers and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt         <= '0;
      c_cnt         <= '0;
      hid_q         <= '0;
      best          <= '0;
      best_idx      <= '0;
      bus.class_idx <= '0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            hid_q <= bus.hidden;
            h_cnt <= '0;
          end
        end
        ACCUM: begin
          if (h_cnt == H_LAST) c_cnt <= '0;
          else                 h_cnt <= h_cnt + 1'b1;
        end
        ARGMAX: begin
          if (take_c) begin
            best     <= score[c_cnt];
            best_idx <= c_cnt;
          end
          if (c_cnt == C_LAST) begin
            bus.class_idx <= win_idx_c;
            bus.done      <= 1'b1;
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_second_layer_tnndirect.sv
// Scoreboard bench for second_layer_tnndirect: three instances with different
// weight/mask sets run in lockstep on shared stimulus; a monitor pops the
// expected result whenever instance A raises done.
module tb_second_layer_tnndirect;

  // Bit h*3+c; col0=1111, col1=0000, col2=1010 (bit h of col2 = h-th char from right).
  localparam logic [11:0] WTS    = 12'b101_001_101_001;
  localparam logic [11:0] M_ALL  = 12'hFFF;
  localparam logic [11:0] M_NONE = 12'h000;
  localparam logic [11:0] M_COL2 = 12'b100_100_100_100;
  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] hidden = 4'd0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    int         due;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0] hv;
    logic [1:0] ea;
    logic [1:0] ec;
  } vec_t;

  second_layer_tnndirect_if #(.HIDDEN_CNT(4), .CLASS_CNT(3)) bus_a ();
  second_layer_tnndirect_if #(.HIDDEN_CNT(4), .CLASS_CNT(3)) bus_b ();
  second_layer_tnndirect_if #(.HIDDEN_CNT(4), .CLASS_CNT(3)) bus_c ();

  assign bus_a.start = start;  assign bus_a.hidden = hidden;
  assign bus_b.start = start;  assign bus_b.hidden = hidden;
  assign bus_c.start = start;  assign bus_c.hidden = hidden;

  second_layer_tnndirect #(.HIDDEN_CNT(4), .CLASS_CNT(3), .WEIGHTS(WTS), .MASK(M_ALL))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  second_layer_tnndirect #(.HIDDEN_CNT(4), .CLASS_CNT(3), .WEIGHTS(WTS), .MASK(M_NONE))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  second_layer_tnndirect #(.HIDDEN_CNT(4), .CLASS_CNT(3), .WEIGHTS(WTS), .MASK(M_COL2))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each rising done of instance A, compare all three results and latency.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus_a.done && !prev_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("idx_a", int'(bus_a.class_idx), int'(e.a));
          check("idx_b", int'(bus_b.class_idx), int'(e.b));
          check("idx_c", int'(bus_c.class_idx), int'(e.c));
          check("done_b", int'(bus_b.done), 1);
          check("done_c", int'(bus_c.done), 1);
          check("latency", cyc, e.due);
        end
      end
      prev_done = bus_a.done;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called #1 after a posedge: the next edge samples start.
  task automatic launch(input logic [3:0] hv, input logic [1:0] ea, input logic [1:0] ec);
    hidden = hv;
    start  = 1'b1;
    sb_q.push_back('{a: ea, b: 2'd0, c: ec, due: cyc + 1 + LAT});
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1 seen = bus_a.done;
    end
    check(name, int'(seen), 1);
  endtask

  vec_t vecs[9];

  initial begin
    // hidden, expected idx A (full mask), expected idx C (col2 only); B is always 0.
    vecs[0] = '{4'b1111, 2'd0, 2'd0};  // scores A (4,-4,0)
    vecs[1] = '{4'b0000, 2'd1, 2'd0};  // A (-4,4,0)
    vecs[2] = '{4'b1010, 2'd2, 2'd2};  // A (0,0,4), C (0,0,4)
    vecs[3] = '{4'b0101, 2'd0, 2'd0};  // A (0,0,-4) tie at 0
    vecs[4] = '{4'b1000, 2'd1, 2'd2};  // A (-2,2,2) tie -> 1
    vecs[5] = '{4'b1110, 2'd0, 2'd2};  // A (2,-2,2) tie -> 0
    vecs[6] = '{4'b0010, 2'd1, 2'd2};  // A (-2,2,2)
    vecs[7] = '{4'b0001, 2'd1, 2'd0};  // A (-2,2,-2), C (0,0,-2)
    vecs[8] = '{4'b0011, 2'd0, 2'd0};  // A (0,0,0)

    repeat (2) @(posedge clk);
    #1;
    check("rst done_a", int'(bus_a.done), 0);
    check("rst idx_a", int'(bus_a.class_idx), 0);
    check("rst done_b", int'(bus_b.done), 0);
    check("rst done_c", int'(bus_c.done), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      launch(vecs[i].hv, vecs[i].ea, vecs[i].ec);
      wait_done($sformatf("done vec%0d", i));
    end

    // Asynchronous reset between edges clears a nonzero result at once.
    do_reset();
    launch(4'b0000, 2'd1, 2'd0);
    wait_done("done pre-async");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async done_a", int'(bus_a.done), 0);
    check("async idx_a", int'(bus_a.class_idx), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;

    // Reset in the second ACCUM cycle, then re-run with start held high.
    do_reset();
    hidden = 4'b0000;
    start  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid done_a", int'(bus_a.done), 0);
    check("mid idx_a", int'(bus_a.class_idx), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.push_back('{a: 2'd1, b: 2'd0, c: 2'd0, due: cyc + 1 + LAT});
    wait_done("done rerun");

    // Drop start and scramble hidden after launch; result must follow the latched value.
    do_reset();
    launch(4'b1000, 2'd1, 2'd2);
    @(posedge clk);
    #1 start = 1'b0;
    hidden = 4'b0111;
    @(posedge clk);
    #1 hidden = 4'b0101;
    wait_done("done toggle");
    start  = 1'b1;
    hidden = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("hold done_a", int'(bus_a.done), 1);
      check("hold idx_a", int'(bus_a.class_idx), 1);
    end

    repeat (3) @(posedge clk);
    #1 check("scoreboard empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
